// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - timestamped branch/fetch trace FIFO fed by CPU debug outputs
// Optional fetch tracing is built in when CPU_TRACE_ALL_FETCH_EN is defined.
module cpu_trace_buffer #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TS_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           debug_pc,
  input  logic [31:0]           debug_instruction,
  input  logic [1:0]            debug_state,
  input  logic                  debug_change_pc,
  input  logic [15:0]           debug_data_address,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [15:0]           rd_pc,
  output logic [15:0]           rd_target,
  output logic [31:0]           rd_instr,
  output logic [TS_W-1:0]       rd_time,
  output logic                  rd_kind,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [7:0]            overflow_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [TS_W-1:0]       ts;
  logic                  prev_change;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic [15:0]     mem_pc    [DEPTH];
  logic [15:0]     mem_tgt   [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic [TS_W-1:0] mem_ts    [DEPTH];

  logic branch_ev;
  logic fetch_ev;
  logic event_hit;
  logic pop;
  logic accept;
  logic drop;

  assign branch_ev = debug_change_pc & ~prev_change;

`ifdef CPU_TRACE_ALL_FETCH_EN
  logic [1:0] prev_state;
  logic       mem_kind [DEPTH];

  assign fetch_ev = (debug_state == 2'd0) && (prev_state != 2'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_state <= 2'd3;
    end else begin
      prev_state <= debug_state;
      if (!clear && accept) begin
        mem_kind[wr_ptr] <= ~branch_ev;
      end
    end
  end

  assign rd_kind = rd_valid ? mem_kind[rd_ptr] : 1'b0;
`else
  logic unused_state;

  assign unused_state = ^debug_state;
  assign fetch_ev     = 1'b0;
  assign rd_kind      = 1'b0;
`endif

  assign event_hit = branch_ev | fetch_ev;
  assign rd_valid  = (count != '0);
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = rd_valid & rd_ready;
  // A pop frees the head slot at the same edge, so a full FIFO can still take a write.
  assign accept    = event_hit & enable & (~full | pop);
  assign drop      = event_hit & enable & ~accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ts           <= '0;
      prev_change  <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else begin
      ts          <= ts + 1'b1;
      prev_change <= debug_change_pc;
      if (clear) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        overflow_cnt <= '0;
      end else begin
        if (accept) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(accept) - CW'(pop);
        if (drop && overflow_cnt != 8'hFF) begin
          overflow_cnt <= overflow_cnt + 1'b1;
        end
      end
    end
  end

  // Entry storage has no reset; the read port is gated by rd_valid instead.
  always_ff @(posedge clk) begin
    if (reset && !clear && accept) begin
      mem_pc[wr_ptr]    <= debug_pc;
      mem_tgt[wr_ptr]   <= branch_ev ? debug_data_address : 16'h0000;
      mem_instr[wr_ptr] <= debug_instruction;
      mem_ts[wr_ptr]    <= ts;
    end
  end

  assign rd_pc     = rd_valid ? mem_pc[rd_ptr]    : '0;
  assign rd_target = rd_valid ? mem_tgt[rd_ptr]   : '0;
  assign rd_instr  = rd_valid ? mem_instr[rd_ptr] : '0;
  assign rd_time   = rd_valid ? mem_ts[rd_ptr]    : '0;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - self-checking bench for cpu_trace_buffer
// Queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_cpu_trace_buffer;

  localparam int DL    = 3;
  localparam int TW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   debug_pc;
  logic [31:0]   debug_instruction;
  logic [1:0]    debug_state;
  logic          debug_change_pc;
  logic [15:0]   debug_data_address;
  logic          enable;
  logic          clear;
  logic          rd_ready;
  logic          rd_valid;
  logic [15:0]   rd_pc;
  logic [15:0]   rd_target;
  logic [31:0]   rd_instr;
  logic [TW-1:0] rd_time;
  logic          rd_kind;
  logic [DL:0]   count;
  logic          full;
  logic          empty;
  logic [7:0]    overflow_cnt;

  cpu_trace_buffer #(.DEPTH_LOG2(DL), .TS_W(TW)) dut (
    .clk(clk), .reset(reset), .debug_pc(debug_pc), .debug_instruction(debug_instruction),
    .debug_state(debug_state), .debug_change_pc(debug_change_pc),
    .debug_data_address(debug_data_address), .enable(enable), .clear(clear),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_target(rd_target),
    .rd_instr(rd_instr), .rd_time(rd_time), .rd_kind(rd_kind), .count(count),
    .full(full), .empty(empty), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   pc;
    logic [15:0]   tgt;
    logic [31:0]   instr;
    logic [TW-1:0] ts;
    logic          kind;
  } ent_t;

  ent_t          q[$];
  ent_t          e;
  logic [TW-1:0] m_ts;
  logic          m_prev_chg;
  logic [1:0]    m_prev_st;
  int            m_ovf;
  bit            m_ok = 1'b0;
  bit            br, fe, full_m, pop_m;

  int n_chk  = 0;
  int n_fail = 0;
  int rel    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: events become queue entries, the queue is the FIFO.
  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_ts       = '0;
      m_prev_chg = 1'b0;
      m_prev_st  = 2'd3;
      m_ovf      = 0;
    end else begin
      br = debug_change_pc && !m_prev_chg;
`ifdef CPU_TRACE_ALL_FETCH_EN
      fe = (debug_state == 2'd0) && (m_prev_st != 2'd0);
`else
      fe = 1'b0;
`endif
      full_m = (q.size() == DEPTH);
      pop_m  = (q.size() > 0) && rd_ready;
      if (clear) begin
        q.delete();
        m_ovf = 0;
      end else begin
        if (pop_m) void'(q.pop_front());
        if ((br || fe) && enable) begin
          if (!full_m || pop_m) begin
            e.pc    = debug_pc;
            e.tgt   = br ? debug_data_address : 16'h0000;
            e.instr = debug_instruction;
            e.ts    = m_ts;
            e.kind  = br ? 1'b0 : 1'b1;
            q.push_back(e);
          end else if (m_ovf < 255) begin
            m_ovf++;
          end
        end
      end
      m_prev_chg = debug_change_pc;
      m_prev_st  = debug_state;
      m_ts       = m_ts + 1'b1;
    end
    m_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("rd_valid", rd_valid, q.size() > 0);
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("overflow_cnt", overflow_cnt, m_ovf);
      if (q.size() > 0) begin
        chk("rd_pc", rd_pc, q[0].pc);
        chk("rd_target", rd_target, q[0].tgt);
        chk("rd_instr", rd_instr, q[0].instr);
        chk("rd_time", rd_time, q[0].ts);
        chk("rd_kind", rd_kind, q[0].kind);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    if (reset) rel++;
    #2;
  endtask

  task automatic pulse(input logic [15:0] pc);
    debug_pc        = pc;
    debug_change_pc = 1'b1;
    step();
    debug_change_pc = 1'b0;
    step();
  endtask

  initial begin
    int            t0;
    logic [TW-1:0] prev_t;

    reset = 1'b0; debug_pc = '0; debug_instruction = '0; debug_state = 2'd1;
    debug_change_pc = 1'b0; debug_data_address = '0; enable = 1'b1; clear = 1'b0;
    rd_ready = 1'b0;

    step(); step();
    chk("reset_empty", empty, 1);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_full", full, 0);
    chk("reset_ovf", overflow_cnt, 0);
    chk("reset_rd_pc", rd_pc, 0);

    reset = 1'b1;
    step(); step(); step();

    debug_pc = 16'h0010; debug_data_address = 16'h0004; debug_instruction = 32'h12345678;
    debug_change_pc = 1'b1;
    t0 = rel;
    step();
    chk("single_valid", rd_valid, 1);
    chk("single_pc", rd_pc, 16'h0010);
    chk("single_target", rd_target, 16'h0004);
    chk("single_instr", rd_instr, 32'h12345678);
    chk("single_kind", rd_kind, 0);
    chk("single_time", rd_time, t0);
    chk("first_time_lit", rd_time, 3);
    step(); step();
    chk("single_count", count, 1);
    debug_change_pc = 1'b0; rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("single_drained", empty, 1);

    for (int i = 0; i < 10; i++) pulse(16'h0100 + 16'(i));
    chk("ovf_count", count, 8);
    chk("ovf_full", full, 1);
    chk("ovf_cnt", overflow_cnt, 2);
    chk("ovf_head_pc", rd_pc, 16'h0100);

    rd_ready = 1'b1; debug_pc = 16'h0200; debug_change_pc = 1'b1;
    step();
    debug_change_pc = 1'b0;
    chk("popwr_count", count, 8);
    chk("popwr_ovf", overflow_cnt, 2);
    chk("popwr_full", full, 1);
    prev_t = '0;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", rd_valid, 1);
      if (i > 0) chk("drain_ts_incr", rd_time > prev_t, 1);
      prev_t = rd_time;
      step();
    end
    rd_ready = 1'b0;
    chk("drain_empty", empty, 1);

    for (int i = 0; i < 10; i++) pulse(16'h0300 + 16'(i));
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rd_ready = 1'b0;
    chk("pre_clear_count", count, 5);
    clear = 1'b1; debug_change_pc = 1'b1; rd_ready = 1'b1;
    step();
    clear = 1'b0; debug_change_pc = 1'b0; rd_ready = 1'b0;
    chk("clear_count", count, 0);
    chk("clear_ovf", overflow_cnt, 0);
    chk("clear_empty", empty, 1);
    step();
    debug_change_pc = 1'b1;
    t0 = rel;
    step();
    debug_change_pc = 1'b0;
    chk("clear_ts_continues", rd_time, t0);
    clear = 1'b1; step(); clear = 1'b0;

`ifdef CPU_TRACE_ALL_FETCH_EN
    debug_pc = 16'h0040;
    debug_state = 2'd0; step();
    debug_state = 2'd1; step();
    debug_state = 2'd2; step();
    debug_state = 2'd0; debug_change_pc = 1'b1; debug_data_address = 16'h0080; step();
    debug_change_pc = 1'b0; debug_state = 2'd1;
    chk("fetch_count", count, 2);
    chk("fetch_kind", rd_kind, 1);
    chk("fetch_target", rd_target, 0);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("fetch_branch_kind", rd_kind, 0);
    chk("fetch_branch_target", rd_target, 16'h0080);
    chk("fetch_count_after", count, 1);
    clear = 1'b1; step(); clear = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
      reset              = ($urandom_range(0, 299) != 0);
      debug_change_pc    = ($urandom_range(0, 2) == 0);
      debug_state        = 2'($urandom_range(0, 3));
      enable             = ($urandom_range(0, 7) != 0);
      clear              = ($urandom_range(0, 49) == 0);
      rd_ready           = ($urandom_range(0, 2) == 0);
      debug_pc           = 16'($urandom);
      debug_data_address = 16'($urandom);
      debug_instruction  = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Downstream trace capture stage for the multi-cycle CPU. It consumes the CPU debug outputs and records a timestamped entry for every taken branch, plus every instruction fetch when the fetch-trace build option is enabled. Entries go into a small FIFO that a bench or debug host drains through a valid/ready read port. The block never back-pressures the CPU: when the FIFO is full, new events are dropped and counted.

## Interface
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 entries (8).
- `TS_W`, default 16: timestamp counter width.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `debug_pc` in 16: CPU program counter.
- `debug_instruction` in 32: CPU current instruction.
- `debug_state` in 2: CPU multi-cycle state; 0 = fetch.
- `debug_change_pc` in 1: CPU branch-taken strobe.
- `debug_data_address` in 16: branch target address.
- `enable` in 1: capture enable; events seen while low are ignored and not counted.
- `clear` in 1: synchronous flush.
- `rd_ready` in 1: consumer accepts the head entry.
- `rd_valid` out 1: head entry is valid.
- `rd_pc` out 16: PC of the head entry.
- `rd_target` out 16: branch target of the head entry; 0 for fetch entries.
- `rd_instr` out 32: instruction of the head entry.
- `rd_time` out TS_W: timestamp of the head entry.
- `rd_kind` out 1: 0 = branch, 1 = fetch.
- `count` out DEPTH_LOG2+1: number of occupied entries.
- `full` out 1.
- `empty` out 1.
- `overflow_cnt` out 8: dropped events, saturates at 255.

## Operation
- **Timestamp counter**
  - Increments every cycle while `reset` is high.
  - Wraps from 2^TS_W−1 to 0.
  - Unaffected by `clear`.
- **Branch event**
  - Fires when `debug_change_pc` is 1 and the registered previous value is 0 (rising edge).
  - `prev_change` resets to 0, so a strobe high on the first cycle after reset counts.
- **Fetch event** (macro only)
  - Fires when `debug_state` is 0 and the registered previous state is not 0.
  - `prev_state` resets to 3, so the first fetch after reset is recorded.
- **Simultaneous events:** if a branch and a fetch fire in the same cycle, exactly one entry is written, with kind = branch.
- **Entry contents:** {pc, target, instr, ts, kind}, all sampled from the inputs and counter in the event cycle.
- **Write acceptance:** a write is accepted when event & `enable` & (!`full` | pop), where pop = `rd_valid` & `rd_ready`.
- **Drop:** an event with `enable` high that is not accepted increments `overflow_cnt` (saturating).
- **Read port:** first-word-fall-through. `rd_*` always presents the head entry; a pop at the clock edge advances the head.
- **Pointers:** read and write pointers are DEPTH_LOG2 bits, wrap modulo depth, and share one register array.
- **Flags:** `full` = (`count` == 2^DEPTH_LOG2); `empty` = (`count` == 0).
- **`clear`:**
  - Sets `count`, both pointers and `overflow_cnt` to 0.
  - Overrides a same-cycle write and pop.
- **Reset values:** every output is 0 except `empty` = 1. This includes `rd_valid`, `rd_*`, `count`, `full` and `overflow_cnt`.
- **Reset mid-operation:** discards all entries and restarts the timestamp at 0.

## Timing
- An event sampled at edge N is visible on `rd_*`, with `rd_valid` = 1, in the cycle after edge N when the FIFO was empty. Write-to-read latency is 1 cycle.
- `count`, `full` and `empty` update at the same edge as the write or pop.
- A pop and a write at the same edge leave `count` unchanged, including when full.
- An event is sampled at most once per input edge, so a change strobe held high for several cycles produces exactly one entry.
- `rd_*` must be stable while `rd_valid` = 1 and `rd_ready` = 0.

## Configuration
- `CPU_TRACE_ALL_FETCH_EN`
  - **Defined:** fetch events are detected and recorded with `rd_kind` = 1 and `rd_target` = 0.
  - **Undefined:** only branch events are recorded. Fetch detection logic and `prev_state` are removed, and `rd_kind` is constant 0.

## Test plan
- **Reset:** hold `reset` = 0 for 2 cycles, then release → `empty` = 1, `rd_valid` = 0, `count` = 0, `overflow_cnt` = 0; `rd_time` of the first entry equals the cycles elapsed since release.
- **Single branch:** pulse `debug_change_pc` high for 3 cycles with pc = 0x0010, target = 0x0004, instr = 0x12345678 → exactly one entry {0x0010, 0x0004, 0x12345678, kind 0}, `rd_valid` high one cycle after the rising edge.
- **Overflow:** 10 branch pulses with `rd_ready` = 0 and DEPTH_LOG2 = 3 → `count` = 8, `full` = 1, `overflow_cnt` = 2; draining returns the first 8 events in order with increasing timestamps.
- **Pop with write when full:** with the FIFO full, drive `rd_ready` = 1 and a branch edge in the same cycle → `count` stays 8 and `overflow_cnt` is unchanged.
- **Clear priority:** assert `clear` in the same cycle as an event and a pop with 5 entries held → `count` = 0, `overflow_cnt` = 0, and the timestamp continues counting.
- **Fetch trace:** with `CPU_TRACE_ALL_FETCH_EN`, drive state sequence 0,1,2,0 plus a branch edge on the second state 0 → two entries: fetch (kind 1), then branch (kind 0) only.
